// File: rtl/m_pte_port_pkg.sv
// Shared types and helpers for the page-walker PTE port: FSM encoding and
// PTE address alignment.
package m_pte_port_pkg;

   typedef enum logic [1:0] {
      PTEP_IDLE  = 2'd0,
      PTEP_ISSUE = 2'd1,
      PTEP_RWAIT = 2'd2,
      PTEP_DONE  = 2'd3
   } ptep_state_e;

   localparam logic [31:0] PTE_ADDR_ALIGN_MASK = 32'h0000_0003;

   function automatic logic pte_misaligned(input logic [31:0] addr);
      return ((addr & PTE_ADDR_ALIGN_MASK) != 32'h0000_0000);
   endfunction

   function automatic logic [31:0] pte_word_addr(input logic [31:0] addr);
      return (addr & ~PTE_ADDR_ALIGN_MASK);
   endfunction

endpackage

// File: rtl/m_pte_port_timeout.sv
// Per-state watchdog for the PTE port: counts while enabled, clears on
// request, and flags the last permitted cycle.
module m_pte_timeout #(
   parameter int TIMEOUT = 256,
   parameter int TO_W    = 9
) (
   input  logic CLK,
   input  logic RST_X,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // next count: clear has priority over enable
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {TO_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         cnt_q <= {TO_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/m_pte_port.sv
// Responder for page-walker PTE reads and A/D write-backs: forwards one access
// at a time to the DRAM controller with a busy handshake and a timeout guard.
module m_pte_port
   import m_pte_port_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int TO_W    = 9
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic        i_pte_req,
   input  logic        i_pte_acs,
   input  logic        i_pte_we,
   input  logic [31:0] i_pte_addr,
   input  logic [31:0] i_pte_wdata,
   output logic        o_busy,
   output logic [31:0] o_odata,
   output logic        o_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ready,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata
);

   ptep_state_e state_q, state_d;
   logic        busy_q, busy_d;
   logic [31:0] odata_q, odata_d;
   logic        err_q, err_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        tmo_clr_s;
   logic        tmo_en_s;
   logic        tmo_exp_s;

   // watchdog restarts on every state change so each wait phase gets a full budget
   assign tmo_en_s  = (state_q == PTEP_ISSUE) || (state_q == PTEP_RWAIT);
   assign tmo_clr_s = (state_d != state_q);

   m_pte_timeout #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .CLK       (CLK),
      .RST_X     (RST_X),
      .clr_i     (tmo_clr_s),
      .en_i      (tmo_en_s),
      .expired_o (tmo_exp_s)
   );

   // next-state and next-output logic; memory progress beats timeout expiry
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      odata_d = odata_q;
      err_d   = err_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         PTEP_IDLE: begin
            if (i_pte_req && i_pte_acs) begin
               busy_d  = 1'b1;
               we_d    = i_pte_we;
               addr_d  = pte_word_addr(i_pte_addr);
               wdata_d = i_pte_wdata;
               if (pte_misaligned(i_pte_addr)) begin
                  err_d   = 1'b1;
                  state_d = PTEP_DONE;
               end else begin
                  err_d   = 1'b0;
                  req_d   = 1'b1;
                  state_d = PTEP_ISSUE;
               end
            end else begin
               state_d = PTEP_IDLE;
            end
         end
         PTEP_ISSUE: begin
            if (i_mem_ready) begin
               req_d   = 1'b0;
               state_d = we_q ? PTEP_DONE : PTEP_RWAIT;
            end else if (tmo_exp_s) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               odata_d = 32'h0000_0000;
               state_d = PTEP_DONE;
            end else begin
               state_d = PTEP_ISSUE;
            end
         end
         PTEP_RWAIT: begin
            if (i_mem_rvalid) begin
               odata_d = i_mem_rdata;
               state_d = PTEP_DONE;
            end else if (tmo_exp_s) begin
               err_d   = 1'b1;
               odata_d = 32'h0000_0000;
               state_d = PTEP_DONE;
            end else begin
               state_d = PTEP_RWAIT;
            end
         end
         PTEP_DONE: begin
            busy_d  = 1'b0;
            state_d = PTEP_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            req_d   = 1'b0;
            state_d = PTEP_IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_q <= PTEP_IDLE;
         busy_q  <= 1'b0;
         odata_q <= 32'h0000_0000;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         odata_q <= odata_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_odata     = odata_q;
   assign o_err       = err_q;
   assign o_mem_req   = req_q;
   assign o_mem_we    = we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;

endmodule
